// File: rtl/avg_frame_ctrl.sv
// avg_frame_ctrl -- frame-level sequencer for a 2x2 averaging kernel.
//
// Walks a ROW x COL frame memory one row pair at a time. Each clock it reads
// one column from both rows (upper = even row, lower = odd row) and feeds
// the pixels to an external 2x2 kernel. Once per even-aligned 2x2 block it
// captures the kernel sum and writes sum/4 to a (ROW/2) x (COL/2) output
// memory in row-major order.
//
// Ports:
//   clk           rising-edge clock
//   en            synchronous active-low reset
//   start         one-cycle pulse, begins a frame (ignored unless idle)
//   busy          high from the cycle after an accepted start to the last write
//   done          one-cycle pulse after the last write
//   rd_en         frame memory read strobe
//   rd_addr_0/1   upper/lower row read addresses
//   rd_data_0/1   upper/lower row read data, one cycle after the address
//   kern_en       kernel enable (low clears the kernel window)
//   kern_din_0/1  kernel pixel inputs
//   kern_row_cnt  kernel row count (odd row of the previous read)
//   kern_col_cnt  kernel column count (column of the previous read)
//   kern_dout     kernel 2x2 sum
//   wr_en         output memory write strobe
//   wr_addr       output memory address
//   wr_data       block average
module avg_frame_ctrl #(
    parameter int WIDTH = 8,
    parameter int ROW   = 480,
    parameter int COL   = 752,
    parameter int AW    = 19,
    parameter int OAW   = 17
) (
    input  logic             clk,
    input  logic             en,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [AW-1:0]    rd_addr_0,
    output logic [AW-1:0]    rd_addr_1,
    input  logic [WIDTH-1:0] rd_data_0,
    input  logic [WIDTH-1:0] rd_data_1,
    output logic             kern_en,
    output logic [WIDTH-1:0] kern_din_0,
    output logic [WIDTH-1:0] kern_din_1,
    output logic [9:0]       kern_row_cnt,
    output logic [9:0]       kern_col_cnt,
    input  logic [WIDTH+1:0] kern_dout,
    output logic             wr_en,
    output logic [OAW-1:0]   wr_addr,
    output logic [WIDTH-1:0] wr_data
);

    localparam int CW = (COL > 1) ? $clog2(COL) : 1;
    localparam int PW = ((ROW / 2) > 1) ? $clog2(ROW / 2) : 1;

    localparam logic [CW-1:0] C_LAST   = CW'(COL - 1);
    localparam logic [PW-1:0] P_LAST   = PW'(ROW / 2 - 1);
    localparam logic [AW-1:0] ROW_STEP = AW'(COL + 1);
    localparam logic [AW-1:0] COL_OFS  = AW'(COL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   col;
    logic [PW-1:0]   pair;
    logic [AW-1:0]   ptr_0;
    logic [AW-1:0]   ptr_1;
    logic [1:0]      drain_cnt;
    logic            odd_d1;
    logic            odd_d2;
    logic            last_rd;

    assign last_rd = (pair == P_LAST) && (col == C_LAST);

    // Pixels go straight to the kernel; the kernel registers them itself.
    assign kern_din_0 = rd_data_0;
    assign kern_din_1 = rd_data_1;

    // State register
    always_ff @(posedge clk) begin
        if (!en) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_rd) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_cnt == 2'd2) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic; addresses are forced to zero whenever no read is issued
    always_comb begin
        busy      = (state == S_RUN) || (state == S_DRAIN);
        done      = (state == S_DONE);
        rd_en     = (state == S_RUN);
        rd_addr_0 = rd_en ? ptr_0 : '0;
        rd_addr_1 = rd_en ? ptr_1 : '0;
    end

    // Read pointers, kernel control and write-back pipeline
    always_ff @(posedge clk) begin
        if (!en) begin
            col          <= '0;
            pair         <= '0;
            ptr_0        <= '0;
            ptr_1        <= '0;
            drain_cnt    <= '0;
            odd_d1       <= 1'b0;
            odd_d2       <= 1'b0;
            kern_en      <= 1'b0;
            kern_row_cnt <= '0;
            kern_col_cnt <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
        end else begin
            kern_en <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);

            // An odd-column read in cycle n completes a block whose sum is
            // on kern_dout in cycle n+2; the write is registered for n+3.
            odd_d1 <= rd_en & col[0];
            odd_d2 <= odd_d1;
            wr_en  <= odd_d2;
            if (odd_d2) begin
                // Truncating divide by four; max sum 4*(2^WIDTH-1) fits exactly.
                wr_data <= WIDTH'(kern_dout >> 2);
            end

            if (state == S_DONE) begin
                wr_addr <= '0;
            end else if (wr_en) begin
                wr_addr <= wr_addr + OAW'(1);
            end

            if (state == S_RUN) begin
                kern_row_cnt <= 10'({pair, 1'b1});
                kern_col_cnt <= 10'(col);
                if (col == C_LAST) begin
                    // Skip over the odd row just read: next pair starts at 2(p+1)*COL.
                    col   <= '0;
                    pair  <= pair + PW'(1);
                    ptr_0 <= ptr_0 + ROW_STEP;
                    ptr_1 <= ptr_1 + ROW_STEP;
                end else begin
                    col   <= col + CW'(1);
                    ptr_0 <= ptr_0 + AW'(1);
                    ptr_1 <= ptr_1 + AW'(1);
                end
            end else begin
                col   <= '0;
                pair  <= '0;
                ptr_0 <= '0;
                ptr_1 <= COL_OFS;
            end

            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
        end
    end

endmodule

// File: tb/tb_avg_frame_ctrl.sv
// Directed bench for avg_frame_ctrl on a 4x4 frame with a behavioural frame
// memory and 2x2 kernel model.
module tb_avg_frame_ctrl;

    localparam int WIDTH = 8;
    localparam int ROW   = 4;
    localparam int COL   = 4;
    localparam int AW    = 4;
    localparam int OAW   = 2;
    localparam int NPIX  = ROW * COL;
    localparam int NOUT  = (ROW / 2) * (COL / 2);
    localparam int NRD   = ROW * COL / 2;
    localparam int SW    = WIDTH + 2;

    logic             clk = 1'b0;
    logic             en;
    logic             start;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [AW-1:0]    rd_addr_0;
    logic [AW-1:0]    rd_addr_1;
    logic [WIDTH-1:0] rd_data_0 = '0;
    logic [WIDTH-1:0] rd_data_1 = '0;
    logic             kern_en;
    logic [WIDTH-1:0] kern_din_0;
    logic [WIDTH-1:0] kern_din_1;
    logic [9:0]       kern_row_cnt;
    logic [9:0]       kern_col_cnt;
    logic [SW-1:0]    kern_dout;
    logic             wr_en;
    logic [OAW-1:0]   wr_addr;
    logic [WIDTH-1:0] wr_data;

    logic [WIDTH-1:0] mem [0:NPIX-1];
    logic [WIDTH-1:0] ku0 = '0, kl0 = '0, ku1 = '0, kl1 = '0;

    int n_cmp = 0;
    int n_err = 0;

    avg_frame_ctrl #(
        .WIDTH (WIDTH),
        .ROW   (ROW),
        .COL   (COL),
        .AW    (AW),
        .OAW   (OAW)
    ) dut (
        .clk          (clk),
        .en           (en),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .rd_en        (rd_en),
        .rd_addr_0    (rd_addr_0),
        .rd_addr_1    (rd_addr_1),
        .rd_data_0    (rd_data_0),
        .rd_data_1    (rd_data_1),
        .kern_en      (kern_en),
        .kern_din_0   (kern_din_0),
        .kern_din_1   (kern_din_1),
        .kern_row_cnt (kern_row_cnt),
        .kern_col_cnt (kern_col_cnt),
        .kern_dout    (kern_dout),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data)
    );

    always #5 clk = ~clk;

    // Frame memory: one-cycle read latency on both ports
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_0 <= mem[rd_addr_0];
            rd_data_1 <= mem[rd_addr_1];
        end
    end

    // Kernel model: two-column window, sum is combinational from registers
    always @(posedge clk) begin
        if (!kern_en) begin
            ku0 <= '0; kl0 <= '0; ku1 <= '0; kl1 <= '0;
        end else begin
            ku0 <= ku1; kl0 <= kl1;
            ku1 <= kern_din_0; kl1 <= kern_din_1;
        end
    end
    assign kern_dout = SW'(ku0) + SW'(kl0) + SW'(ku1) + SW'(kl1);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},    32'(busy),         0);
        check({tag, "_done"},    32'(done),         0);
        check({tag, "_rd_en"},   32'(rd_en),        0);
        check({tag, "_kern_en"}, 32'(kern_en),      0);
        check({tag, "_wr_en"},   32'(wr_en),        0);
        check({tag, "_ra0"},     32'(rd_addr_0),    0);
        check({tag, "_ra1"},     32'(rd_addr_1),    0);
        check({tag, "_wa"},      32'(wr_addr),      0);
        check({tag, "_wd"},      32'(wr_data),      0);
        check({tag, "_rowc"},    32'(kern_row_cnt), 0);
        check({tag, "_colc"},    32'(kern_col_cnt), 0);
    endtask

    function automatic logic [WIDTH-1:0] gold(input int idx);
        int br, bc, a;
        logic [SW-1:0] s;
        br = idx / (COL / 2);
        bc = idx % (COL / 2);
        a  = 2 * br * COL + 2 * bc;
        s  = SW'(mem[a]) + SW'(mem[a+1]) + SW'(mem[a+COL]) + SW'(mem[a+COL+1]);
        return s[SW-1:2];
    endfunction

    // Starts a frame in the current cycle and follows it to done. Returns at
    // the sample point of the done cycle.
    task automatic run_frame(input int poke_cyc, input bit poke_done,
                             output int nwr, output int last_addr, output int last_data);
        int cyc;
        int nrd;
        int exp_a0;
        bit seen;
        cyc = 0; nrd = 0; seen = 0;
        nwr = 0; last_addr = -1; last_data = -1;
        start = 1'b1;
        while (!seen && cyc < 200) begin
            tick();
            cyc++;
            start = (cyc == poke_cyc);
            if (rd_en) begin
                nrd++;
                check("rd_gap", cyc, nrd);
                exp_a0 = 2 * ((nrd - 1) / COL) * COL + (nrd - 1) % COL;
                check("rd_addr_0", 32'(rd_addr_0), exp_a0);
                check("rd_addr_diff", 32'(rd_addr_1) - 32'(rd_addr_0), COL);
            end
            if (wr_en) begin
                check("wr_addr", 32'(wr_addr), nwr);
                check("wr_data", 32'(wr_data), 32'(gold(nwr)));
                last_addr = int'(wr_addr);
                last_data = int'(wr_data);
                nwr++;
            end
            check("busy", 32'(busy), 32'(!done));
            if (done) begin
                seen = 1;
                check("done_cyc", cyc, NRD + 4);
                start = poke_done;
            end
        end
        check("done_seen", 32'(seen), 1);
        check("rd_total", nrd, NRD);
    endtask

    int nwr, la, ld;
    int wa[4] = '{0, 1, 2, 3};
    int wd[4] = '{2, 4, 10, 12};

    initial begin
        en = 1'b0;
        start = 1'b0;
        for (int k = 0; k < NPIX; k++) mem[k] = WIDTH'(k);

        // Reset state
        repeat (3) tick();
        check_zero("rst");

        // start together with reset: reset wins
        start = 1'b1;
        tick();
        check_zero("rst_start");
        en = 1'b1;
        start = 1'b0;
        tick();
        check("rst_win_busy", 32'(busy), 0);

        // Ramp image pixel(r,c)=4r+c, start in cycle 0
        start = 1'b1;
        for (int cyc = 1; cyc <= 13; cyc++) begin
            bit exp_wr;
            int ea0;
            tick();
            start = 1'b0;
            exp_wr = (cyc == 5) || (cyc == 7) || (cyc == 9) || (cyc == 11);
            check("ramp_rd_en", 32'(rd_en), 32'(cyc <= 8));
            check("ramp_wr_en", 32'(wr_en), 32'(exp_wr));
            check("ramp_done", 32'(done), 32'(cyc == 12));
            check("ramp_busy", 32'(busy), 32'(cyc <= 11));
            check("ramp_kern_en", 32'(kern_en), 32'(cyc <= 11));
            if (exp_wr) begin
                check("ramp_wr_addr", 32'(wr_addr), wa[(cyc - 5) / 2]);
                check("ramp_wr_data", 32'(wr_data), wd[(cyc - 5) / 2]);
            end
            if (cyc <= 8) begin
                ea0 = (cyc <= 4) ? cyc - 1 : cyc + 3;
                check("ramp_ra0", 32'(rd_addr_0), ea0);
                check("ramp_ra1", 32'(rd_addr_1), ea0 + 4);
            end
            if (cyc == 2) begin
                check("ramp_row_c2", 32'(kern_row_cnt), 1);
                check("ramp_col_c2", 32'(kern_col_cnt), 0);
            end
            if (cyc == 6) begin
                check("ramp_row_c6", 32'(kern_row_cnt), 3);
                check("ramp_col_c6", 32'(kern_col_cnt), 0);
            end
            if (cyc == 9) begin
                check("ramp_row_c9", 32'(kern_row_cnt), 3);
                check("ramp_col_c9", 32'(kern_col_cnt), 3);
            end
        end

        // All pixels at maximum
        for (int k = 0; k < NPIX; k++) mem[k] = '1;
        run_frame(0, 0, nwr, la, ld);
        check("max_nwr", nwr, NOUT);
        check("max_last_addr", la, NOUT - 1);
        check("max_last_data", ld, 255);
        tick();
        check("max_done_pulse", 32'(done), 0);

        // Random image
        for (int k = 0; k < NPIX; k++) mem[k] = WIDTH'($urandom);
        run_frame(0, 0, nwr, la, ld);
        check("rand_nwr", nwr, NOUT);
        tick();

        // Reset for one cycle in the middle of RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        en = 1'b0;
        tick();
        check_zero("midrst");
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("midrst_wr_en", 32'(wr_en), 0);
            check("midrst_busy", 32'(busy), 0);
        end
        for (int k = 0; k < NPIX; k++) mem[k] = WIDTH'($urandom);
        run_frame(0, 0, nwr, la, ld);
        check("after_rst_nwr", nwr, NOUT);
        tick();

        // start pulsed during RUN and during DONE: both ignored
        run_frame(3, 1, nwr, la, ld);
        check("poke_nwr", nwr, NOUT);
        tick();
        start = 1'b0;
        check("poke_done_busy", 32'(busy), 0);
        check("poke_done_rd_en", 32'(rd_en), 0);
        tick();
        check("poke_idle_busy", 32'(busy), 0);
        run_frame(0, 0, nwr, la, ld);
        check("post_poke_nwr", nwr, NOUT);

        // Back-to-back: second start the cycle after done
        tick();
        run_frame(0, 0, nwr, la, ld);
        check("b2b_first_nwr", nwr, NOUT);
        tick();
        run_frame(0, 0, nwr, la, ld);
        check("b2b_second_nwr", nwr, NOUT);
        check("b2b_last_addr", la, NOUT - 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/avg_frame_ctrl.md
Name: avg_frame_ctrl

Overview:
- Frame-level sequencer for the 2x2 averaging kernel; produces a half-resolution image.
- Walks a ROW x COL frame memory in row pairs and issues two-port reads (upper row / lower row) at one column per clock, with no bubbles.
- Drives the kernel's data, count and enable inputs, and captures the 2x2 sum once per even-aligned block.
- Writes the block average (sum/4) to an output memory at (ROW/2) x (COL/2) resolution.

Parameters:
- WIDTH, 8, pixel width; the kernel sum is WIDTH+2 bits.
- ROW, 480, frame rows; must be even.
- COL, 752, frame columns; must be even.
- AW, 19, frame memory address width; must satisfy ROW*COL <= 2^AW.
- OAW, 17, output memory address width; must satisfy (ROW/2)*(COL/2) <= 2^OAW.

Ports:
- clk  in  1  clock, rising edge.
- en  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame.
- busy  out  1  high from the cycle after an accepted start through the last write.
- done  out  1  one-cycle pulse after the last write.
- rd_en  out  1  frame memory read strobe.
- rd_addr_0  out  AW  upper-row (even row) read address.
- rd_addr_1  out  AW  lower-row (odd row) read address.
- rd_data_0  in  WIDTH  upper-row data; valid 1 cycle after its address.
- rd_data_1  in  WIDTH  lower-row data; valid 1 cycle after its address.
- kern_en  out  1  kernel enable; low clears the kernel window.
- kern_din_0  out  WIDTH  to kernel din_0.
- kern_din_1  out  WIDTH  to kernel din_1.
- kern_row_cnt  out  10  to kernel row_cnt.
- kern_col_cnt  out  10  to kernel col_cnt.
- kern_dout  in  WIDTH+2  kernel 2x2 sum (combinational from kernel registers).
- wr_en  out  1  output memory write strobe.
- wr_addr  out  OAW  output address.
- wr_data  out  WIDTH  block average.

Behaviour:
- en low at a rising edge: state IDLE; all counters and address pointers 0; every output 0 (busy, done, rd_en, kern_en, wr_en, all addresses and data). Applies mid-frame too: the frame is abandoned with no further reads or writes, and the output memory is left partially written.
- FSM states IDLE, RUN, DRAIN, DONE.
  - IDLE: on start go to RUN. kern_en=0, busy=0.
  - RUN: rd_en=1 every cycle. Column c runs 0..COL-1 and pair p runs 0..ROW/2-1.
    - rd_addr_0 = 2p*COL+c and rd_addr_1 = rd_addr_0+COL, both kept as incrementing pointers (no multiplier).
    - At c=COL-1 the pointers advance by COL+1.
    - After the read with p=ROW/2-1 and c=COL-1, go to DRAIN.
  - DRAIN: rd_en=0; hold 3 cycles, then go to DONE.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- kern_en is registered: 1 in RUN and DRAIN, 0 otherwise. It rises in the same cycle as the first rd_en.
- Datapath:
  - kern_din_0 = rd_data_0 and kern_din_1 = rd_data_1, passed straight through.
  - kern_row_cnt / kern_col_cnt = row/col of the read issued one cycle earlier; row = 2p+1, zero-extended to 10 bits.
- Capture timing: for a read of an odd column issued in cycle n, kern_dout holds the full 2x2 block sum in cycle n+2.
  - Register wr_en=1, wr_data=kern_dout[WIDTH+1:2] (truncating divide by 4) in cycle n+3.
  - Maximum sum 4*(2^WIDTH-1) gives exactly 2^WIDTH-1, so no overflow.
- wr_addr starts at 0 and increments by 1 after each write, row-major over (ROW/2)x(COL/2).
- Total writes per frame: (ROW/2)*(COL/2). Last write occurs in the final DRAIN cycle; done follows in the next cycle.
- start while busy or in DONE: ignored.
- start and en low in the same cycle: reset wins.

Test Plan:
- Ramp image, ROW=4, COL=4, pixel(r,c)=4r+c, start at cycle 0.
  - rd_en high in cycles 1-8.
  - wr_en in cycles 5, 7, 9, 11 with (addr,data) = (0,2), (1,4), (2,10), (3,12).
  - done in cycle 12.
- All pixels 255, default ROW/COL -> every wr_data=255; exactly 90240 writes; last wr_addr=90239; done once.
- Default size, random image -> every write equals the golden floor(sum/4); rd_addr_1-rd_addr_0=752 throughout; no gap in rd_en across row-pair boundaries.
- en low for 1 cycle mid-RUN -> next cycle all outputs 0, state IDLE, no further writes; a new start produces a complete, correct frame.
- start pulsed during RUN and during DONE -> ignored; write count unchanged; next start after IDLE accepted.
- Back-to-back frames, start issued the cycle after done -> second frame identical to the first; wr_addr restarts at 0.
